// File: rtl/clause_queue.sv
// Per-lane clause FIFO between the clause arbiter grant and a BCP engine.
// Registered full/valid, no fall-through, single-cycle flush, sticky overflow.
module clause_queue #(
    parameter int ELEMENT_CNT     = 16,
    parameter int CLAUSE_WIDTH    = 3,
    parameter int ELEMENT_BIT_CNT = $clog2(ELEMENT_CNT) + 1,
    parameter int DEPTH           = 8,
    parameter int CW              = CLAUSE_WIDTH * ELEMENT_BIT_CNT,
    parameter int PW              = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          grant_in,
    input  logic [CW-1:0] clause_in,
    output logic          full_out,
    output logic          clause_valid_out,
    output logic [CW-1:0] clause_out,
    input  logic          clause_ready_in,
    input  logic          flush_in,
    output logic [PW:0]   count_out,
    output logic          overflow_err
);

    localparam int CNTW = PW + 1;

    logic [CW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            full, valid, push, pop;

    // Status is decoded from the registered count only, so the arbiter
    // never sees a combinational path back from grant/ready/flush.
    assign full  = (count_q == CNTW'(DEPTH));
    assign valid = (count_q != '0);

    assign full_out         = full;
    assign clause_valid_out = valid;
    assign clause_out       = mem[rd_ptr_q];
    assign count_out        = count_q;
    assign overflow_err     = overflow_q;

    // Next-state: flush wins over push/pop; a grant while full is dropped.
    always_comb begin
        push       = grant_in & ~full & ~flush_in;
        pop        = clause_ready_in & valid & ~flush_in;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (grant_in & full & ~flush_in);
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CNTW'(push) - CNTW'(pop);
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; only written on an accepted push.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= clause_in;
    end

endmodule

// File: tb/tb_clause_queue.sv
// Directed self-checking bench for clause_queue.
// One task per scenario, inline comparisons against hand-computed values.
module tb_clause_queue;

    localparam int CW    = 15;
    localparam int PW    = 3;
    localparam int DEPTH = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          grant_in = 1'b0;
    logic [CW-1:0] clause_in = '0;
    logic          full_out;
    logic          clause_valid_out;
    logic [CW-1:0] clause_out;
    logic          clause_ready_in = 1'b0;
    logic          flush_in = 1'b0;
    logic [PW:0]   count_out;
    logic          overflow_err;

    int vectors = 0;
    int miscompares = 0;

    clause_queue dut (
        .clock            (clock),
        .reset            (reset),
        .grant_in         (grant_in),
        .clause_in        (clause_in),
        .full_out         (full_out),
        .clause_valid_out (clause_valid_out),
        .clause_out       (clause_out),
        .clause_ready_in  (clause_ready_in),
        .flush_in         (flush_in),
        .count_out        (count_out),
        .overflow_err     (overflow_err)
    );

    always #5 clock = ~clock;

    // Advance one rising edge, then settle 1ns past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        grant_in = 1'b0;
        clause_ready_in = 1'b0;
        flush_in = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        #2 reset = 1'b0;
        step();
        #2 reset = 1'b1;
        step();
    endtask

    task automatic push_n(input int n, input logic [CW-1:0] base);
        for (int i = 0; i < n; i++) begin
            grant_in = 1'b1;
            clause_in = base + CW'(i);
            step();
        end
        grant_in = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (count_out !== 4'd0 || full_out !== 1'b0 || clause_valid_out !== 1'b0 || overflow_err !== 1'b0) begin
            $display("FAIL reset_init: cnt=%0d full=%b val=%b ovf=%b want 0 0 0 0", count_out, full_out, clause_valid_out, overflow_err);
            miscompares++;
        end
        step();
        #2 reset = 1'b1;
        step();
        push_n(5, 15'h0050);
        vectors++;
        if (count_out !== 4'd5) begin
            $display("FAIL reset_pre: cnt=%0d want 5", count_out);
            miscompares++;
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (count_out !== 4'd0 || full_out !== 1'b0 || clause_valid_out !== 1'b0) begin
            $display("FAIL reset_async: cnt=%0d full=%b val=%b want 0 0 0", count_out, full_out, clause_valid_out);
            miscompares++;
        end
        #1 reset = 1'b1;
        grant_in = 1'b1;
        clause_in = 15'h0777;
        step();
        grant_in = 1'b0;
        vectors++;
        if (count_out !== 4'd1 || clause_out !== 15'h0777) begin
            $display("FAIL reset_first_push: cnt=%0d data=%h want 1 0777", count_out, clause_out);
            miscompares++;
        end
        apply_reset();
    endtask

    task automatic test_fill();
        push_n(8, 15'h0001);
        vectors++;
        if (count_out !== 4'd8 || full_out !== 1'b1 || overflow_err !== 1'b0) begin
            $display("FAIL fill_full: cnt=%0d full=%b ovf=%b want 8 1 0", count_out, full_out, overflow_err);
            miscompares++;
        end
        grant_in = 1'b1;
        clause_in = 15'h0009;
        clause_ready_in = 1'b1;
        step();
        idle();
        vectors++;
        if (count_out !== 4'd7 || overflow_err !== 1'b1) begin
            $display("FAIL fill_overflow: cnt=%0d ovf=%b want 7 1", count_out, overflow_err);
            miscompares++;
        end
        for (int i = 2; i <= 8; i++) begin
            vectors++;
            if (clause_valid_out !== 1'b1 || clause_out !== CW'(i)) begin
                $display("FAIL fill_order: val=%b data=%h want 1 %h", clause_valid_out, clause_out, CW'(i));
                miscompares++;
            end
            clause_ready_in = 1'b1;
            step();
        end
        clause_ready_in = 1'b1;
        step();
        clause_ready_in = 1'b0;
        vectors++;
        if (count_out !== 4'd0 || clause_valid_out !== 1'b0 || overflow_err !== 1'b1) begin
            $display("FAIL fill_empty: cnt=%0d val=%b ovf=%b want 0 0 1", count_out, clause_valid_out, overflow_err);
            miscompares++;
        end
        apply_reset();
    endtask

    task automatic test_empty_latency();
        grant_in = 1'b1;
        clause_in = 15'h1234;
        #1;
        vectors++;
        if (clause_valid_out !== 1'b0) begin
            $display("FAIL latency_n: val=%b want 0", clause_valid_out);
            miscompares++;
        end
        step();
        grant_in = 1'b0;
        vectors++;
        if (clause_valid_out !== 1'b1 || clause_out !== 15'h1234) begin
            $display("FAIL latency_n1: val=%b data=%h want 1 1234", clause_valid_out, clause_out);
            miscompares++;
        end
        clause_ready_in = 1'b1;
        step();
        clause_ready_in = 1'b1;
        step();
        clause_ready_in = 1'b0;
        vectors++;
        if (count_out !== 4'd0 || overflow_err !== 1'b0) begin
            $display("FAIL empty_ready: cnt=%0d ovf=%b want 0 0", count_out, overflow_err);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        logic [CW-1:0] exp[$];
        push_n(3, 15'h0100);
        for (int i = 0; i < 3; i++) exp.push_back(15'h0100 + CW'(i));
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (clause_out !== exp[0]) begin
                $display("FAIL b2b_data: got %h want %h", clause_out, exp[0]);
                miscompares++;
            end
            void'(exp.pop_front());
            grant_in = 1'b1;
            clause_ready_in = 1'b1;
            clause_in = 15'h0200 + CW'(i);
            exp.push_back(clause_in);
            step();
            vectors++;
            if (count_out !== 4'd3) begin
                $display("FAIL b2b_count: got %0d want 3", count_out);
                miscompares++;
            end
        end
        grant_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (clause_out !== exp[0]) begin
                $display("FAIL b2b_drain: got %h want %h", clause_out, exp[0]);
                miscompares++;
            end
            void'(exp.pop_front());
            clause_ready_in = 1'b1;
            step();
        end
        idle();
    endtask

    task automatic test_flush();
        push_n(6, 15'h0300);
        grant_in = 1'b1;
        clause_in = 15'h03ff;
        clause_ready_in = 1'b1;
        flush_in = 1'b1;
        step();
        idle();
        vectors++;
        if (count_out !== 4'd0 || clause_valid_out !== 1'b0 || overflow_err !== 1'b0) begin
            $display("FAIL flush_basic: cnt=%0d val=%b ovf=%b want 0 0 0", count_out, clause_valid_out, overflow_err);
            miscompares++;
        end
        push_n(8, 15'h0400);
        grant_in = 1'b1;
        clause_in = 15'h04ff;
        flush_in = 1'b1;
        step();
        idle();
        vectors++;
        if (count_out !== 4'd0 || overflow_err !== 1'b0) begin
            $display("FAIL flush_full: cnt=%0d ovf=%b want 0 0", count_out, overflow_err);
            miscompares++;
        end
        push_n(2, 15'h0500);
        vectors++;
        if (count_out !== 4'd2 || clause_out !== 15'h0500) begin
            $display("FAIL flush_after: cnt=%0d data=%h want 2 0500", count_out, clause_out);
            miscompares++;
        end
        flush_in = 1'b1;
        step();
        idle();
    endtask

    task automatic test_wrap();
        logic [CW-1:0] exp[$];
        int pushed = 0;
        int popped = 0;
        int cyc = 0;
        logic g, r;
        while ((pushed < 20 || popped < 20) && cyc < 1000) begin
            g = (pushed < 20) && ($urandom_range(0, 3) != 0) && (exp.size() < DEPTH);
            r = (popped < 20) && ($urandom_range(0, 2) == 0) && (exp.size() > 0);
            if (r) begin
                vectors++;
                if (clause_out !== exp[0]) begin
                    $display("FAIL wrap_data: got %h want %h", clause_out, exp[0]);
                    miscompares++;
                end
                void'(exp.pop_front());
                popped++;
            end
            grant_in = g;
            clause_ready_in = r;
            clause_in = 15'h6000 + CW'(pushed * 37);
            if (g) begin
                exp.push_back(clause_in);
                pushed++;
            end
            step();
            cyc++;
            vectors++;
            if (count_out !== (PW+1)'(exp.size())) begin
                $display("FAIL wrap_count: got %0d want %0d", count_out, exp.size());
                miscompares++;
            end
        end
        idle();
        vectors++;
        if (cyc >= 1000) begin
            $display("FAIL wrap_timeout: cycles=%0d limit 1000", cyc);
            miscompares++;
        end
        vectors++;
        if (overflow_err !== 1'b0) begin
            $display("FAIL wrap_ovf: got %b want 0", overflow_err);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_empty_latency();
        test_back_to_back();
        test_flush();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
